// File: rtl/slot_tx_pkg.sv
// Shared types and defaults for the slot-pulse transmitter.
// SYM_W matches the RX counter's num port so both ends agree on symbol width.
package slot_tx_pkg;
  localparam int SYM_W           = 7;
  localparam int SLOT_CYCLES_DEF = 20;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_t;

  // Pulse length is the symbol value saturated at the slot length.
  function automatic sym_t clamp_len(input sym_t v, input sym_t lim);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/sym_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
// There is no fall-through: a written word becomes poppable on the following edge.
module sym_fifo #(
  parameter int  DEPTH  = 4,
  parameter type data_t = logic [7:0]
) (
  input  logic  CLOCK_200m,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  data_t wdata,
  output data_t rdata,
  output logic  full,
  output logic  empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sym_fifo: DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  data_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge CLOCK_200m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      empty <= (count_nxt == '0);
    end
  end

  // Storage is not reset; the flags alone decide what is valid.
  always_ff @(posedge CLOCK_200m) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/slot_pulse_tx.sv
// Slot-pulse transmitter: each buffered symbol becomes a pulse of that many clocks
// at the start of a fixed SLOT_CYCLES-clock slot on outputIO.
//
//   state | meaning
//   IDLE  | output low, waiting for enable and a buffered symbol
//   RUN   | slots back to back; enable and FIFO sampled only at the slot boundary
module slot_pulse_tx
  import slot_tx_pkg::*;
#(
  parameter int SLOT_CYCLES = SLOT_CYCLES_DEF,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        CLOCK_200m,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sym_valid,
  input  logic [6:0]  sym_data,
  output logic        sym_ready,
  output logic        outputIO,
  output logic        slot_start,
  output logic [7:0]  underrun_cnt,
  output logic [15:0] sent_cnt
);
  generate
    if (SLOT_CYCLES < 2 || SLOT_CYCLES > 127) begin : g_bad_slot
      $error("slot_pulse_tx: SLOT_CYCLES must be in 2..127");
    end
  endgenerate

  localparam sym_t SLOT_LEN  = sym_t'(SLOT_CYCLES);
  localparam sym_t SLOT_LAST = sym_t'(SLOT_CYCLES - 1);

  tx_state_t state, state_nxt;
  sym_t      slot_cnt, slot_cnt_nxt;
  sym_t      cur_len, cur_len_nxt;
  sym_t      fifo_rdata;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_pop;
  logic      out_nxt;
  logic      start_nxt;
  logic      sent_inc;
  logic      under_inc;

  assign sym_ready = !fifo_full;

  sym_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .data_t (sym_t)
  ) u_fifo (
    .CLOCK_200m (CLOCK_200m),
    .rst_n      (rst_n),
    .push       (sym_valid && sym_ready),
    .pop        (fifo_pop),
    .wdata      (sym_data),
    .rdata      (fifo_rdata),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_comb begin
    state_nxt    = state;
    slot_cnt_nxt = slot_cnt;
    cur_len_nxt  = cur_len;
    fifo_pop     = 1'b0;
    start_nxt    = 1'b0;
    sent_inc     = 1'b0;
    under_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          fifo_pop     = 1'b1;
          cur_len_nxt  = clamp_len(fifo_rdata, SLOT_LEN);
          slot_cnt_nxt = '0;
          start_nxt    = 1'b1;
          sent_inc     = 1'b1;
          state_nxt    = RUN;
        end
      end
      RUN: begin
        if (slot_cnt == SLOT_LAST) begin
          slot_cnt_nxt = '0;
          if (!enable) begin
            cur_len_nxt = '0;
            state_nxt   = IDLE;
          end else if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            cur_len_nxt = clamp_len(fifo_rdata, SLOT_LEN);
            start_nxt   = 1'b1;
            sent_inc    = 1'b1;
          end else begin
            cur_len_nxt = '0;
            start_nxt   = 1'b1;
            under_inc   = 1'b1;
          end
        end else begin
          slot_cnt_nxt = slot_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Output is registered, so it is computed from the values entering the next cycle.
    out_nxt = (state_nxt == RUN) && (slot_cnt_nxt < cur_len_nxt);
  end

  always_ff @(posedge CLOCK_200m or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      slot_cnt     <= '0;
      cur_len      <= '0;
      outputIO     <= 1'b0;
      slot_start   <= 1'b0;
      sent_cnt     <= '0;
      underrun_cnt <= '0;
    end else begin
      state      <= state_nxt;
      slot_cnt   <= slot_cnt_nxt;
      cur_len    <= cur_len_nxt;
      outputIO   <= out_nxt;
      slot_start <= start_nxt;
      if (sent_inc) sent_cnt <= sent_cnt + 16'd1;
      if (under_inc && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
endmodule

// File: doc/slot_pulse_tx.md
Name: slot_pulse_tx

Overview:
- Transmit-side counterpart of the slot-counting receiver.
- Accepts 7-bit symbols over a valid/ready stream and buffers them in a small FIFO.
- Emits each symbol on outputIO as a pulse inside a fixed slot of SLOT_CYCLES clocks at 200 MHz. The pulse width in clocks equals the symbol value, clamped to the slot length.
- Sits at the TX pin driver; the RX counter at the far end recovers the value by counting high samples per slot.

Parameters:
SLOT_CYCLES, 20, clocks per slot. Legal range 2..127; out-of-range values are a elaboration-time error.
FIFO_DEPTH, 4, symbol buffer depth. Power of 2, at least 2.

Ports:
CLOCK_200m  input  1  sample/transmit clock
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  transmit enable; sampled at slot boundaries only
sym_valid  input  1  symbol offered
sym_data  input  7  symbol value (requested high clocks)
sym_ready  output  1  FIFO can accept; equals !full (registered)
outputIO  output  1  registered serial pulse output
slot_start  output  1  one-clock pulse during slot cycle 0 of every RUN slot
underrun_cnt  output  8  slots sent empty because FIFO was empty; saturates at 255
sent_cnt  output  16  symbols popped and transmitted; wraps

Behaviour:
- Reset (async, immediate):
  - FIFO emptied; sym_ready=1.
  - outputIO=0, slot_start=0, underrun_cnt=0, sent_cnt=0.
  - FSM=IDLE, slot_cnt=0, cur_len=0.
  - Reset asserted mid-slot truncates the pulse immediately; no resume.
- Push: on an edge with sym_valid && sym_ready, sym_data is written. No fall-through: a pushed word can be popped at the next edge at the earliest.
- Same-edge push and pop on a non-full FIFO are both performed; occupancy is unchanged.
- Length: len = min(sym_data, SLOT_CYCLES). Values above SLOT_CYCLES are clamped; for example 127 gives a fully-high slot.
- FSM states: IDLE and RUN.
  - IDLE: outputIO=0 and slot_start=0. At an edge where enable=1 and the FIFO is non-empty: pop, load cur_len, slot_cnt←0, go to RUN, sent_cnt+1. This is the "slot edge 0".
  - RUN: slot_cnt advances 0..SLOT_CYCLES-1, one per clock.
  - In RUN, at the edge ending slot_cnt=SLOT_CYCLES-1 (the boundary):
    - enable=1 and FIFO non-empty: pop, load cur_len, slot_cnt←0, stay RUN, sent_cnt+1.
    - enable=1 and FIFO empty: cur_len←0 (a low slot), slot_cnt←0, stay RUN, underrun_cnt+1 (saturating).
    - enable=0: go to IDLE. The current slot always completes; enable is never sampled mid-slot.
- Output timing: during slot cycle k (the clock period after slot edge k), outputIO = (k < cur_len). slot_start=1 during cycle k=0 only.
- Latency: pop edge → first high outputIO is 0 clocks; it is visible in the period after the pop edge.
- Back-to-back slots have no gap cycles. With a continuously fed FIFO the slot period is exactly SLOT_CYCLES clocks.
- Width rules:
  - slot_cnt and cur_len are 7 bits.
  - sent_cnt wraps at 16 bits.
  - underrun_cnt holds at 8'hFF.
- The FIFO never over/underflows: sym_ready gates push, the FSM checks empty before pop.

Decomposition:
- Package slot_tx_pkg holds:
  - SYM_W=7, the symbol width, shared with the RX num port.
  - typedef sym_t (logic [SYM_W-1:0]).
  - typedef enum tx_state_t {IDLE, RUN}.
  - Default SLOT_CYCLES=20.
- Sub-module sym_fifo holds the synchronous FIFO:
  - Parameters DEPTH and data type.
  - Ports: push, pop, wdata, rdata, full, empty, registered flags.
- Top module holds the FSM, slot counter, pulse comparator and statistics counters.

Test Plan:
- Reset, then push 5 with enable=1 → at the pop edge slot_start=1; outputIO high for exactly 5 clocks, then low for 15; sent_cnt=1. With the FIFO then empty, each further slot stays low and underrun_cnt increments once per 20 clocks.
- Stream 0, 20, 7, 127 back-to-back → per-slot high counts 0, 20, 7, 20. Slots are contiguous, slot_start every 20 clocks, no gap between the 20-high and 7-high slots.
- Push 6 symbols while enable=0 → sym_ready falls after the 4th accept; symbols 5–6 are held by the source. Raising enable drains in order; sym_ready returns 1 the cycle after the first pop.
- Deassert enable at slot cycle 3 of a len=10 slot → the full 10-high pulse completes, the FSM enters IDLE at the boundary, and outputIO stays 0 thereafter.
- Keep enable=1 with an empty FIFO for 300 slots → underrun_cnt saturates at 255 and outputIO stays 0. Pushing 3 then gives a 3-high slot at the next boundary.
- Assert rst_n=0 at slot cycle 2 of a len=15 slot → outputIO drops immediately; all counters read 0 and sym_ready=1. After release, nothing is transmitted until new symbols are pushed.
